dilithium_op_sequencer: RTL and testbench
=========================================

Name: dilithium_op_sequencer

Overview:
- Controller between the host-facing start/mode interface and the low-resource Dilithium core's op port.
- Decodes the requested operation and issues exactly one opcode to the core with a valid/ready handshake.
- Tracks output-stream beats against the expected word count for the configured security level, then reports completion.
- Adds a stall watchdog and reports errors for illegal modes and hung operations.

Parameters:
- SEC_LEVEL, 2: Dilithium security level (2, 3 or 5). Selects the expected output word counts.
- TIMEOUT_CYCLES, 65535: consecutive cycles with no stream beat in RUN before the operation is aborted as hung.
- CNT_W, 12: width of the output word counter. Must hold 1864.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request to begin an operation. Sampled only in IDLE.
- mode, in, 2: operation select. 0 keygen, 1 sign, 2 verify, 3 reserved.
- op_o, out, 4: opcode presented to the core.
- op_valid_o, out, 1: opcode valid.
- core_ready_i, in, 1: core is ready to accept an opcode.
- in_fire_i, in, 1: input stream beat (valid_i & ready_i).
- out_fire_i, in, 1: output stream beat (valid_o & ready_o).
- busy_o, out, 1: operation in progress.
- done_o, out, 1: one-cycle completion pulse.
- error_o, out, 1: one-cycle error pulse, coincident with done_o.
- word_cnt_o, out, CNT_W: output beats counted in the current operation.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset forces IDLE and drives all outputs to 0 (op_o = 0, counters = 0). It takes effect from any state, including mid-operation. No done_o or error_o pulse is produced by a reset.
- Opcodes: OP_KEYGEN = 4'h1, OP_SIGN = 4'h2, OP_VERIFY = 4'h3.
- Expected output words (EXP):
  - SEC 2: keygen 960, sign 605, verify 1.
  - SEC 3: keygen 1488, sign 824, verify 1.
  - SEC 5: keygen 1864, sign 1149, verify 1.
- State IDLE:
  - busy_o = 0.
  - start & mode != 3: latch mode and EXP, go to ISSUE.
  - start & mode == 3: go to ERR.
  - Otherwise stay in IDLE.
- State ISSUE:
  - busy_o = 1, op_valid_o = 1, op_o = opcode. op_o is held stable until accepted.
  - Handshake completes on the cycle where op_valid_o & core_ready_i. Next cycle: RUN, with word_cnt_o = 0 and watchdog = 0.
  - The watchdog also runs in ISSUE. Expiry goes to ERR.
- State RUN:
  - busy_o = 1, op_valid_o = 0.
  - Each out_fire_i increments word_cnt_o by 1.
  - Watchdog clears on any in_fire_i or out_fire_i and otherwise increments.
  - out_fire_i while word_cnt_o == EXP-1: go to DONE. word_cnt_o ends at EXP.
  - Watchdog reaching TIMEOUT_CYCLES-1 with no beat: go to ERR. A beat in that same cycle takes priority and clears the watchdog.
  - out_fire_i after EXP is reached cannot occur, because the FSM has already left RUN.
- State DONE: done_o = 1 for one cycle, busy_o = 0, then IDLE. word_cnt_o holds its value until the next ISSUE.
- State ERR: done_o = 1 and error_o = 1 for one cycle, then IDLE.
- start outside IDLE is ignored. start held high in IDLE re-triggers on the cycle after DONE/ERR returns to IDLE, so back-to-back operations are legal.
- Latency:
  - start to op_valid_o: 1 cycle.
  - Last output beat to done_o: 1 cycle.
- Counters saturate-free: EXP always fits within CNT_W. A SEC_LEVEL outside {2, 3, 5} is a elaboration-time fatal error.

Decomposition:
- Package dilithium_ctrl_pkg holds:
  - mode_e (KEYGEN, SIGN, VERIFY, RSVD);
  - the opcode constants;
  - state_e (IDLE, ISSUE, RUN, DONE, ERR);
  - function exp_words(sec_level, mode), returning the EXP values above.
- One sub-module is natural: dilithium_stall_watchdog, a counter with clear, enable, TIMEOUT parameter and expired output.

Test Plan:
- SEC 2, mode 0, core_ready_i high: op_o = 1 with op_valid_o = 1 for 1 cycle. Drive 960 out_fire_i beats. done_o pulses on the cycle after the 960th beat, with word_cnt_o = 960 and error_o = 0.
- SEC 2, mode 2, core_ready_i held low for 10 cycles: op_valid_o and op_o = 3 stay stable for 11 cycles. One out beat gives done_o. Repeat with SEC 5 keygen, which must need 1864 beats.
- mode 3 with start: done_o = 1 and error_o = 1 exactly 1 cycle after start. op_valid_o never rises.
- SEC 3 sign with TIMEOUT_CYCLES = 16: 100 beats, then stall. error_o pulses 16 cycles after the last beat. A beat arriving on cycle 15 of a stall must prevent the error.
- Assert rst in RUN after 300 beats: next cycle IDLE with all outputs 0 and no done_o. A following start runs cleanly from word_cnt_o = 0.
- start held high across two operations: the second ISSUE follows DONE with exactly one IDLE cycle in between. start pulsed during RUN is ignored.

Source files
------------

// File: rtl/dilithium_ctrl_pkg.sv
// Shared types, opcodes and expected-word-count table for the Dilithium op sequencer.
package dilithium_ctrl_pkg;

  typedef enum logic [1:0] {
    KEYGEN = 2'd0,
    SIGN   = 2'd1,
    VERIFY = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [3:0] OP_NONE   = 4'h0;
  localparam logic [3:0] OP_KEYGEN = 4'h1;
  localparam logic [3:0] OP_SIGN   = 4'h2;
  localparam logic [3:0] OP_VERIFY = 4'h3;

  localparam int EXP_W = 12;

  function automatic logic sec_level_ok(input int sec_level);
    return (sec_level == 2) || (sec_level == 3) || (sec_level == 5);
  endfunction

  // Output-stream length of each operation, in core words.
  function automatic logic [EXP_W-1:0] exp_words(input int sec_level, input mode_e mode);
    logic [EXP_W-1:0] w;
    w = 12'd0;
    case (mode)
      KEYGEN: begin
        case (sec_level)
          3:       w = 12'd1488;
          5:       w = 12'd1864;
          default: w = 12'd960;
        endcase
      end
      SIGN: begin
        case (sec_level)
          3:       w = 12'd824;
          5:       w = 12'd1149;
          default: w = 12'd605;
        endcase
      end
      VERIFY:  w = 12'd1;
      default: w = 12'd0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] opcode(input mode_e mode);
    logic [3:0] op;
    case (mode)
      KEYGEN:  op = OP_KEYGEN;
      SIGN:    op = OP_SIGN;
      VERIFY:  op = OP_VERIFY;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/dilithium_stall_watchdog.sv
// Stall counter: counts enabled cycles without a clear and flags the cycle it would hit TIMEOUT-1.
module dilithium_stall_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear (beat or handshake) in the limit cycle suppresses expiry.
  assign expired_o = en_i && !clr_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/dilithium_op_sequencer.sv
// Issues one opcode per host request to the Dilithium core, counts output beats to completion
// and aborts with an error pulse on reserved modes or stalled operations.
module dilithium_op_sequencer
  import dilithium_ctrl_pkg::*;
#(
  parameter int SEC_LEVEL      = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [3:0]       op_o,
  output logic             op_valid_o,
  input  logic             core_ready_i,
  input  logic             in_fire_i,
  input  logic             out_fire_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  if (!sec_level_ok(SEC_LEVEL)) begin : g_bad_sec_level
    $fatal(1, "dilithium_op_sequencer: SEC_LEVEL must be 2, 3 or 5");
  end

  if (int'(exp_words(SEC_LEVEL, KEYGEN)) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $fatal(1, "dilithium_op_sequencer: CNT_W too narrow for the keygen word count");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [3:0]       op_q, op_d;
  logic             op_valid_q, op_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic wd_en_s;
  logic wd_clr_s;
  logic wd_expired_s;

  assign wd_en_s  = (state_q == ISSUE) || (state_q == RUN);
  assign wd_clr_s = !wd_en_s
                 || ((state_q == ISSUE) && core_ready_i)
                 || ((state_q == RUN) && (in_fire_i || out_fire_i));

  dilithium_stall_watchdog #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // Next-state logic plus outputs decoded from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    exp_d      = exp_q;
    word_cnt_d = word_cnt_q;
    op_d       = OP_NONE;
    op_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode_e'(mode) == RSVD) begin
            state_d = ERR;
          end else begin
            state_d    = ISSUE;
            mode_d     = mode_e'(mode);
            exp_d      = CNT_W'(exp_words(SEC_LEVEL, mode_e'(mode)));
            word_cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (core_ready_i) begin
          state_d    = RUN;
          word_cnt_d = {CNT_W{1'b0}};
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = ISSUE;
        end
      end
      RUN: begin
        if (out_fire_i) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (word_cnt_q == exp_q - CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (wd_expired_s) begin
          state_d = ERR;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      ISSUE: begin
        op_d       = opcode(mode_d);
        op_valid_d = 1'b1;
        busy_d     = 1'b1;
      end
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      ERR: begin
        done_d  = 1'b1;
        error_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= KEYGEN;
      exp_q      <= {CNT_W{1'b0}};
      word_cnt_q <= {CNT_W{1'b0}};
      op_q       <= OP_NONE;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      exp_q      <= exp_d;
      word_cnt_q <= word_cnt_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign op_o       = op_q;
  assign op_valid_o = op_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_dilithium_op_sequencer.sv
// Directed bench: three sequencers (SEC 2, SEC 3 with a 16-cycle watchdog, SEC 5) share one stimulus.
module tb_dilithium_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic core_ready = 1'b0;
  logic in_fire = 1'b0;
  logic out_fire = 1'b0;

  logic [3:0]  op2, op3, op5;
  logic        vld2, vld3, vld5;
  logic        busy2, busy3, busy5;
  logic        done2, done3, done5;
  logic        err2, err3, err5;
  logic [11:0] wc2, wc3, wc5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dilithium_op_sequencer #(.SEC_LEVEL(2), .TIMEOUT_CYCLES(65535), .CNT_W(12)) u_s2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_o(op2), .op_valid_o(vld2),
    .core_ready_i(core_ready), .in_fire_i(in_fire), .out_fire_i(out_fire),
    .busy_o(busy2), .done_o(done2), .error_o(err2), .word_cnt_o(wc2));

  dilithium_op_sequencer #(.SEC_LEVEL(3), .TIMEOUT_CYCLES(16), .CNT_W(12)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_o(op3), .op_valid_o(vld3),
    .core_ready_i(core_ready), .in_fire_i(in_fire), .out_fire_i(out_fire),
    .busy_o(busy3), .done_o(done3), .error_o(err3), .word_cnt_o(wc3));

  dilithium_op_sequencer #(.SEC_LEVEL(5), .TIMEOUT_CYCLES(65535), .CNT_W(12)) u_s5 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_o(op5), .op_valid_o(vld5),
    .core_ready_i(core_ready), .in_fire_i(in_fire), .out_fire_i(out_fire),
    .busy_o(busy5), .done_o(done5), .error_o(err5), .word_cnt_o(wc5));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0; mode = 2'd0; in_fire = 1'b0; out_fire = 1'b0; core_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({op2, vld2, busy2, done2, err2, wc2} !== 20'd0) begin
      errors++; $display("FAIL reset_s2: got %h expected 0", {op2, vld2, busy2, done2, err2, wc2});
    end
    checks++;
    if ({op3, vld3, busy3, done3, err3, wc3, op5, vld5, busy5, done5, err5, wc5} !== 40'd0) begin
      errors++; $display("FAIL reset_s3_s5: got %h expected 0",
                         {op3, vld3, busy3, done3, err3, wc3, op5, vld5, busy5, done5, err5, wc5});
    end
  endtask

  task automatic test_keygen_s2();
    do_reset();
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    checks++;
    if ({vld2, op2, busy2} !== 6'b1_0001_1) begin
      errors++; $display("FAIL kg2_issue: got vld/op/busy=%b expected 1_0001_1", {vld2, op2, busy2});
    end
    tick();
    checks++;
    if ({vld2, busy2, wc2} !== {1'b0, 1'b1, 12'd0}) begin
      errors++; $display("FAIL kg2_run_entry: got vld=%b busy=%b wc=%0d expected 0 1 0", vld2, busy2, wc2);
    end
    out_fire = 1'b1;
    repeat (959) tick();
    checks++;
    if (wc2 !== 12'd959 || done2 !== 1'b0) begin
      errors++; $display("FAIL kg2_959: got wc=%0d done=%b expected 959 0", wc2, done2);
    end
    tick();
    out_fire = 1'b0;
    checks++;
    if ({done2, err2, busy2, wc2} !== {1'b1, 1'b0, 1'b0, 12'd960}) begin
      errors++; $display("FAIL kg2_done: got done=%b err=%b busy=%b wc=%0d expected 1 0 0 960",
                         done2, err2, busy2, wc2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || wc2 !== 12'd960) begin
      errors++; $display("FAIL kg2_after: got done=%b wc=%0d expected 0 960", done2, wc2);
    end
  endtask

  task automatic test_verify_backpressure();
    do_reset();
    core_ready = 1'b0;
    start = 1'b1; mode = 2'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (vld2 !== 1'b1 || op2 !== 4'h3) begin
        errors++; $display("FAIL vf_hold_%0d: got vld=%b op=%h expected 1 3", k, vld2, op2);
      end
      tick();
    end
    core_ready = 1'b1;
    checks++;
    if (vld2 !== 1'b1 || op2 !== 4'h3) begin
      errors++; $display("FAIL vf_hold_10: got vld=%b op=%h expected 1 3", vld2, op2);
    end
    tick();
    checks++;
    if (vld2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++; $display("FAIL vf_accept: got vld=%b busy=%b expected 0 1", vld2, busy2);
    end
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    checks++;
    if ({done2, err2, wc2} !== {1'b1, 1'b0, 12'd1}) begin
      errors++; $display("FAIL vf_done: got done=%b err=%b wc=%0d expected 1 0 1", done2, err2, wc2);
    end
  endtask

  task automatic test_keygen_s5();
    do_reset();
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    checks++;
    if (vld5 !== 1'b1 || op5 !== 4'h1) begin
      errors++; $display("FAIL kg5_issue: got vld=%b op=%h expected 1 1", vld5, op5);
    end
    tick();
    out_fire = 1'b1;
    repeat (1863) tick();
    checks++;
    if (wc5 !== 12'd1863 || done5 !== 1'b0) begin
      errors++; $display("FAIL kg5_1863: got wc=%0d done=%b expected 1863 0", wc5, done5);
    end
    tick();
    out_fire = 1'b0;
    checks++;
    if (done5 !== 1'b1 || err5 !== 1'b0 || wc5 !== 12'd1864) begin
      errors++; $display("FAIL kg5_done: got done=%b err=%b wc=%0d expected 1 0 1864", done5, err5, wc5);
    end
    checks++;
    if (wc3 !== 12'd1488 || wc2 !== 12'd960) begin
      errors++; $display("FAIL kg_counts_s3_s2: got %0d %0d expected 1488 960", wc3, wc2);
    end
  endtask

  task automatic test_reserved_mode();
    do_reset();
    start = 1'b1; mode = 2'd3;
    tick();
    start = 1'b0;
    checks++;
    if ({done2, err2, vld2, busy2} !== 4'b1100) begin
      errors++; $display("FAIL rsvd_err: got done/err/vld/busy=%b expected 1100", {done2, err2, vld2, busy2});
    end
    tick();
    checks++;
    if ({done2, err2, vld2, busy2} !== 4'b0000) begin
      errors++; $display("FAIL rsvd_after: got done/err/vld/busy=%b expected 0000", {done2, err2, vld2, busy2});
    end
  endtask

  task automatic test_timeout();
    // A 16-cycle watchdog expires on the 16th consecutive beat-less cycle; error_o follows next cycle.
    do_reset();
    start = 1'b1; mode = 2'd1;
    tick();
    start = 1'b0;
    tick();
    out_fire = 1'b1;
    repeat (100) tick();
    out_fire = 1'b0;
    checks++;
    if (wc3 !== 12'd100 || busy3 !== 1'b1) begin
      errors++; $display("FAIL to_100: got wc=%0d busy=%b expected 100 1", wc3, busy3);
    end
    repeat (15) tick();
    checks++;
    if (err3 !== 1'b0 || busy3 !== 1'b1) begin
      errors++; $display("FAIL to_pre_rescue: got err=%b busy=%b expected 0 1", err3, busy3);
    end
    in_fire = 1'b1;
    tick();
    in_fire = 1'b0;
    checks++;
    if (err3 !== 1'b0 || busy3 !== 1'b1 || wc3 !== 12'd100) begin
      errors++; $display("FAIL to_rescue: got err=%b busy=%b wc=%0d expected 0 1 100", err3, busy3, wc3);
    end
    repeat (15) tick();
    checks++;
    if (err3 !== 1'b0 || busy3 !== 1'b1) begin
      errors++; $display("FAIL to_pre_expire: got err=%b busy=%b expected 0 1", err3, busy3);
    end
    tick();
    checks++;
    if ({done3, err3, busy3} !== 3'b110) begin
      errors++; $display("FAIL to_expire: got done/err/busy=%b expected 110", {done3, err3, busy3});
    end
    tick();
    checks++;
    if ({done3, err3} !== 2'b00) begin
      errors++; $display("FAIL to_after: got done/err=%b expected 00", {done3, err3});
    end
    // Same limit applies while the core withholds ready in ISSUE.
    do_reset();
    core_ready = 1'b0;
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    repeat (15) tick();
    checks++;
    if (vld3 !== 1'b1 || err3 !== 1'b0) begin
      errors++; $display("FAIL to_issue_pre: got vld=%b err=%b expected 1 0", vld3, err3);
    end
    tick();
    checks++;
    if ({done3, err3, vld3} !== 3'b110) begin
      errors++; $display("FAIL to_issue_expire: got done/err/vld=%b expected 110", {done3, err3, vld3});
    end
    core_ready = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    tick();
    out_fire = 1'b1;
    repeat (300) tick();
    out_fire = 1'b0;
    checks++;
    if (wc2 !== 12'd300 || busy2 !== 1'b1) begin
      errors++; $display("FAIL rr_300: got wc=%0d busy=%b expected 300 1", wc2, busy2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({op2, vld2, busy2, done2, err2, wc2} !== 20'd0) begin
      errors++; $display("FAIL rr_cleared: got %h expected 0", {op2, vld2, busy2, done2, err2, wc2});
    end
    tick();
    checks++;
    if (done2 !== 1'b0 || err2 !== 1'b0) begin
      errors++; $display("FAIL rr_no_done: got done=%b err=%b expected 0 0", done2, err2);
    end
    start = 1'b1; mode = 2'd2;
    tick();
    start = 1'b0;
    checks++;
    if (vld2 !== 1'b1 || op2 !== 4'h3 || wc2 !== 12'd0) begin
      errors++; $display("FAIL rr_restart: got vld=%b op=%h wc=%0d expected 1 3 0", vld2, op2, wc2);
    end
    tick();
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    checks++;
    if (done2 !== 1'b1 || err2 !== 1'b0 || wc2 !== 12'd1) begin
      errors++; $display("FAIL rr_done: got done=%b err=%b wc=%0d expected 1 0 1", done2, err2, wc2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1; mode = 2'd2;
    tick();
    tick();
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    checks++;
    if (done2 !== 1'b1) begin
      errors++; $display("FAIL b2b_done1: got done=%b expected 1", done2);
    end
    tick();
    checks++;
    if ({busy2, vld2, done2} !== 3'b000) begin
      errors++; $display("FAIL b2b_idle_gap: got busy/vld/done=%b expected 000", {busy2, vld2, done2});
    end
    tick();
    start = 1'b0;
    checks++;
    if (vld2 !== 1'b1 || op2 !== 4'h3) begin
      errors++; $display("FAIL b2b_reissue: got vld=%b op=%h expected 1 3", vld2, op2);
    end
    tick();
    start = 1'b1; mode = 2'd3;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if ({busy2, done2, err2, vld2} !== 4'b1000) begin
      errors++; $display("FAIL b2b_start_ignored: got busy/done/err/vld=%b expected 1000",
                         {busy2, done2, err2, vld2});
    end
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    checks++;
    if (done2 !== 1'b1 || err2 !== 1'b0) begin
      errors++; $display("FAIL b2b_done2: got done=%b err=%b expected 1 0", done2, err2);
    end
    tick();
    tick();
    checks++;
    if ({busy2, vld2, done2} !== 3'b000) begin
      errors++; $display("FAIL b2b_final_idle: got busy/vld/done=%b expected 000", {busy2, vld2, done2});
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_keygen_s2();
    test_verify_backpressure();
    test_keygen_s5();
    test_reserved_mode();
    test_timeout();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
